led_pattern_arbiter: RTL and testbench
======================================

// Module: led_pattern_arbiter
// PURPOSE
//  Arbitrates four prioritized requesters (Identify, Fault, BIOS-POST, Normal) for one bi-colour status LED.
//  Drives the active-low green/red pins with solid or blink patterns timed off Strobe16ms.
//  Sits between the system registers and the front-panel LED pins, alongside the FAN/PSU/LAN LED logic.
//  Gated by power state in the parent.
//  Optionally runs a power-on lamp-test sequence before normal arbitration.
// PARAMETERS
//  SLOW_HALF  31  Strobe16ms ticks per half-period of the 1 Hz blink (~0.5 s)
//  FAST_HALF  8   Strobe16ms ticks per half-period of the 4 Hz blink (~128 ms)
//  LAMP_STEP  31  Strobe16ms ticks per lamp-test step
// PORTS
//  SlowClock   in   1   oscillator clock, 32,768 Hz
//  Reset_N     in   1   reset; asynchronous, active-low
//  Strobe16ms  in   1   single-SlowClock pulse every 16 ms
//  ReqValid    in   4   request per source: [3] Identify, [2] Fault, [1] BIOS-POST, [0] Normal
//  ReqPattern  in   12  3-bit pattern code per source; source n uses [3n+2:3n]
//  LED_G_N     out  1   green LED, active-low
//  LED_R_N     out  1   red LED, active-low
//  ActiveSrc   out  2   index of the granted source (0 when Idle)
//  Idle        out  1   1 = no request granted, LEDs off
//  LampTest    out  1   1 = lamp-test sequence in progress
// BEHAVIOUR
//  Pattern codes:
//   0 off; 1 green; 2 red; 3 amber (both on)
//   4 green blink 1 Hz; 5 red blink 1 Hz; 6 red blink 4 Hz
//   7 alternate green/red 1 Hz
//  Fixed priority: 3 > 2 > 1 > 0. Evaluation is strobe-gated.
//   ReqValid and ReqPattern are sampled only on SlowClock edges where Strobe16ms=1.
//   Changes between strobes are ignored.
//  Simultaneous drop of the winner and rise of another source on the same strobe:
//   the highest valid source after sampling wins; there is no hold time.
//  Grant change, or a pattern-code change from the same source, restarts both blink counters.
//   The blink phase restarts in the "on" half (green for code 7).
//  Blink counters advance only on a strobe.
//   Slow counter: 0..SLOW_HALF-1, wraps to 0 and toggles slow_ph.
//   Fast counter: 0..FAST_HALF-1, wraps to 0 and toggles fast_ph.
//   Both counters also advance while Idle.
//  Outputs are registered. A change sampled on strobe edge k is visible on the pins from edge k+1 (latency 1 clk).
//  No ReqValid bit set: Idle=1, ActiveSrc=0, LED_G_N=LED_R_N=1.
//  Reset values:
//   LED_G_N=1, LED_R_N=1, ActiveSrc=0, Idle=1
//   LampTest=1 with the macro, 0 without
//   Counters=0, phases=on
//  Reset asserted mid-operation: all state returns to reset values immediately (asynchronous).
//   With the macro, the lamp test restarts from LT_RED.
// CONFIGURATION
//  LED_LAMPTEST_EN defined:
//   FSM LT_RED -> LT_GREEN -> LT_OFF -> RUN.
//   Each step lasts LAMP_STEP strobes. LT_RED drives red on; LT_GREEN drives green on; LT_OFF drives both off.
//   LampTest=1 in all states except RUN. Requests are ignored until RUN.
//   RUN is terminal until reset.
//  LED_LAMPTEST_EN not defined:
//   No FSM; the block is always in RUN and LampTest is tied to 0.
//   Arbitration starts at the first strobe after reset.
// STRUCTURE
//  Shared define header led_pattern_defs.vh:
//   pattern codes (`LED_PAT_OFF .. `LED_PAT_ALT)
//   source indices
//   lamp-test state encodings
//  Sub-module led_blink_timer (SlowClock, Reset_N, Strobe16ms, Restart -> SlowPhase, FastPhase).
//   One instance; holds both counters and phase bits.
//  Top level holds the sampled-request registers, priority encoder, lamp-test FSM and pattern decode.
// TESTING
//  1. Reset, macro on:
//     red on for 31 strobes, green on for 31, off for 31, then LampTest=0.
//     Requests raised during the test are ignored.
//  2. ReqValid=4'b0001, Normal pattern=1 -> LED_G_N=0, LED_R_N=1, ActiveSrc=0, Idle=0 one clock after the next strobe.
//  3. Normal=1 active, then Fault raised with pattern=6 -> ActiveSrc=2.
//     Red toggles every 8 strobes, starting on.
//     Drop Fault -> back to solid green.
//  4. Fault and Identify raised on the same strobe -> ActiveSrc=3.
//     A ReqValid pulse that rises and falls between strobes produces no change.
//  5. Identify pattern=7 -> green 31 strobes, red 31 strobes, repeat.
//     Pattern rewritten to 4 mid-period -> restarts with green on, full 31-strobe half-period.
//  6. Assert Reset_N=0 mid-blink between clock edges -> all outputs reach reset values without a clock edge.
//     Release -> sequence restarts.

Source files
------------

// File: rtl/led_pattern_arbiter_pkg.sv
// Shared constants for the status-LED arbiter: pattern codes, source indices,
// lamp-test state encodings and the pattern-to-drive decode helper.
package led_pattern_arbiter_pkg;

  localparam logic [2:0] LED_PAT_OFF    = 3'd0;
  localparam logic [2:0] LED_PAT_GREEN  = 3'd1;
  localparam logic [2:0] LED_PAT_RED    = 3'd2;
  localparam logic [2:0] LED_PAT_AMBER  = 3'd3;
  localparam logic [2:0] LED_PAT_G_SLOW = 3'd4;
  localparam logic [2:0] LED_PAT_R_SLOW = 3'd5;
  localparam logic [2:0] LED_PAT_R_FAST = 3'd6;
  localparam logic [2:0] LED_PAT_ALT    = 3'd7;

  localparam logic [1:0] SRC_NORMAL   = 2'd0;
  localparam logic [1:0] SRC_BIOS     = 2'd1;
  localparam logic [1:0] SRC_FAULT    = 2'd2;
  localparam logic [1:0] SRC_IDENTIFY = 2'd3;

  localparam logic [1:0] LT_RED   = 2'd0;
  localparam logic [1:0] LT_GREEN = 2'd1;
  localparam logic [1:0] LT_OFF   = 2'd2;
  localparam logic [1:0] LT_RUN   = 2'd3;

  typedef struct packed {
    logic       idle;
    logic [1:0] src;
    logic [2:0] pat;
  } grant_t;

  typedef struct packed {
    logic green;
    logic red;
  } drive_t;

  // Phase inputs are 1 during the "on" half of each blink period.
  function automatic drive_t pattern_drive(input logic [2:0] pat,
                                           input logic       slow_on,
                                           input logic       fast_on);
    drive_t d;
    d = '{green: 1'b0, red: 1'b0};
    case (pat)
      LED_PAT_OFF:    d = '{green: 1'b0, red: 1'b0};
      LED_PAT_GREEN:  d.green = 1'b1;
      LED_PAT_RED:    d.red = 1'b1;
      LED_PAT_AMBER:  d = '{green: 1'b1, red: 1'b1};
      LED_PAT_G_SLOW: d.green = slow_on;
      LED_PAT_R_SLOW: d.red = slow_on;
      LED_PAT_R_FAST: d.red = fast_on;
      LED_PAT_ALT:    d = '{green: slow_on, red: !slow_on};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/led_blink_timer.sv
// Strobe-driven 1 Hz and 4 Hz blink phase generators; Restart forces both
// counters to zero and both phases back to the "on" half.
module led_blink_timer #(
  parameter int SLOW_HALF = 31,
  parameter int FAST_HALF = 8
) (
  input  logic SlowClock,
  input  logic Reset_N,
  input  logic Strobe16ms,
  input  logic Restart,
  output logic SlowPhase,
  output logic FastPhase
);

  localparam int SW = (SLOW_HALF > 1) ? $clog2(SLOW_HALF) : 1;
  localparam int FW = (FAST_HALF > 1) ? $clog2(FAST_HALF) : 1;

  logic [SW-1:0] slow_cnt;
  logic [FW-1:0] fast_cnt;

  always_ff @(posedge SlowClock or negedge Reset_N) begin
    if (!Reset_N) begin
      slow_cnt  <= '0;
      fast_cnt  <= '0;
      SlowPhase <= 1'b1;
      FastPhase <= 1'b1;
    end else if (Restart) begin
      slow_cnt  <= '0;
      fast_cnt  <= '0;
      SlowPhase <= 1'b1;
      FastPhase <= 1'b1;
    end else if (Strobe16ms) begin
      if (slow_cnt == SW'(SLOW_HALF - 1)) begin
        slow_cnt  <= '0;
        SlowPhase <= !SlowPhase;
      end else begin
        slow_cnt <= slow_cnt + 1'b1;
      end
      if (fast_cnt == FW'(FAST_HALF - 1)) begin
        fast_cnt  <= '0;
        FastPhase <= !FastPhase;
      end else begin
        fast_cnt <= fast_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_pattern_arbiter.sv
// Four-source priority arbiter for one bi-colour status LED with blink patterns.
// Define LED_LAMPTEST_EN to run a red/green/off lamp test after reset.
module led_pattern_arbiter
  import led_pattern_arbiter_pkg::*;
#(
  parameter int SLOW_HALF = 31,
  parameter int FAST_HALF = 8,
  parameter int LAMP_STEP = 31
) (
  input  logic        SlowClock,
  input  logic        Reset_N,
  input  logic        Strobe16ms,
  input  logic [3:0]  ReqValid,
  input  logic [11:0] ReqPattern,
  output logic        LED_G_N,
  output logic        LED_R_N,
  output logic [1:0]  ActiveSrc,
  output logic        Idle,
  output logic        LampTest
);

  logic [1:0] lt_state;
  logic       run_mode;

`ifdef LED_LAMPTEST_EN
  localparam int STEP_W = (LAMP_STEP > 1) ? $clog2(LAMP_STEP) : 1;
  logic [STEP_W-1:0] step_cnt;

  // Lamp test walks red -> green -> off once, then stays in RUN until reset.
  always_ff @(posedge SlowClock or negedge Reset_N) begin
    if (!Reset_N) begin
      lt_state <= LT_RED;
      step_cnt <= '0;
    end else if (Strobe16ms && lt_state != LT_RUN) begin
      if (step_cnt == STEP_W'(LAMP_STEP - 1)) begin
        step_cnt <= '0;
        case (lt_state)
          LT_RED:   lt_state <= LT_GREEN;
          LT_GREEN: lt_state <= LT_OFF;
          default:  lt_state <= LT_RUN;
        endcase
      end else begin
        step_cnt <= step_cnt + 1'b1;
      end
    end
  end
`else
  assign lt_state = LT_RUN;
`endif

  assign run_mode = (lt_state == LT_RUN);
  assign LampTest = !run_mode;

  logic [2:0] req_pat [4];
  grant_t     winner;
  grant_t     grant_q;
  logic       take_sample;
  logic       restart;
  logic       slow_ph;
  logic       fast_ph;
  drive_t     drive;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_pat[i] = ReqPattern[3*i +: 3];
    end
  end

  always_comb begin
    winner = '{idle: 1'b1, src: SRC_NORMAL, pat: LED_PAT_OFF};
    if (ReqValid[SRC_IDENTIFY])
      winner = '{idle: 1'b0, src: SRC_IDENTIFY, pat: req_pat[SRC_IDENTIFY]};
    else if (ReqValid[SRC_FAULT])
      winner = '{idle: 1'b0, src: SRC_FAULT, pat: req_pat[SRC_FAULT]};
    else if (ReqValid[SRC_BIOS])
      winner = '{idle: 1'b0, src: SRC_BIOS, pat: req_pat[SRC_BIOS]};
    else if (ReqValid[SRC_NORMAL])
      winner = '{idle: 1'b0, src: SRC_NORMAL, pat: req_pat[SRC_NORMAL]};
  end

  // A new winner or a new code from the same winner restarts the blink phase.
  assign take_sample = Strobe16ms && run_mode;
  assign restart     = take_sample && (winner != grant_q);

  always_ff @(posedge SlowClock or negedge Reset_N) begin
    if (!Reset_N)
      grant_q <= '{idle: 1'b1, src: SRC_NORMAL, pat: LED_PAT_OFF};
    else if (take_sample)
      grant_q <= winner;
  end

  led_blink_timer #(
    .SLOW_HALF (SLOW_HALF),
    .FAST_HALF (FAST_HALF)
  ) u_blink (
    .SlowClock  (SlowClock),
    .Reset_N    (Reset_N),
    .Strobe16ms (Strobe16ms),
    .Restart    (restart),
    .SlowPhase  (slow_ph),
    .FastPhase  (fast_ph)
  );

  always_comb begin
    drive = '{green: 1'b0, red: 1'b0};
    case (lt_state)
      LT_RED:   drive.red = 1'b1;
      LT_GREEN: drive.green = 1'b1;
      LT_OFF:   drive = '{green: 1'b0, red: 1'b0};
      default: begin
        if (!grant_q.idle)
          drive = pattern_drive(grant_q.pat, slow_ph, fast_ph);
      end
    endcase
  end

  // Pins and status lag the sampling strobe by one clock.
  always_ff @(posedge SlowClock or negedge Reset_N) begin
    if (!Reset_N) begin
      LED_G_N   <= 1'b1;
      LED_R_N   <= 1'b1;
      ActiveSrc <= 2'd0;
      Idle      <= 1'b1;
    end else begin
      LED_G_N   <= !drive.green;
      LED_R_N   <= !drive.red;
      ActiveSrc <= grant_q.src;
      Idle      <= grant_q.idle;
    end
  end

endmodule

// File: tb/tb_led_pattern_arbiter.sv
// Self-checking bench for led_pattern_arbiter against a behavioural model.
// Honours LED_LAMPTEST_EN the same way the design does.
module tb_led_pattern_arbiter;

  localparam int SLOW = 31;
  localparam int FAST = 8;
  localparam int LAMP = 31;
  localparam int STROBE_PERIOD = 3;
`ifdef LED_LAMPTEST_EN
  localparam int LAMP_TOTAL = 3 * LAMP;
  localparam logic EXP_LAMP_RST = 1'b1;
`else
  localparam int LAMP_TOTAL = 0;
  localparam logic EXP_LAMP_RST = 1'b0;
`endif

  logic        SlowClock = 1'b0;
  logic        Reset_N;
  logic        Strobe16ms;
  logic [3:0]  ReqValid;
  logic [11:0] ReqPattern;
  logic        LED_G_N;
  logic        LED_R_N;
  logic [1:0]  ActiveSrc;
  logic        Idle;
  logic        LampTest;

  always #5 SlowClock = ~SlowClock;

  led_pattern_arbiter dut (
    .SlowClock  (SlowClock),
    .Reset_N    (Reset_N),
    .Strobe16ms (Strobe16ms),
    .ReqValid   (ReqValid),
    .ReqPattern (ReqPattern),
    .LED_G_N    (LED_G_N),
    .LED_R_N    (LED_R_N),
    .ActiveSrc  (ActiveSrc),
    .Idle       (Idle),
    .LampTest   (LampTest)
  );

  int errors = 0;
  int checks = 0;

  // Model: strobes since the last restart, strobes into the lamp test, current grant.
  int   m_since;
  int   m_lamp;
  logic m_idle;
  int   m_src;
  int   m_pat;
  logic exp_g_n, exp_r_n, exp_idle, exp_lamp;
  logic [1:0] exp_src;

  function automatic logic [11:0] pats(input int p3, input int p2, input int p1, input int p0);
    return {3'(p3), 3'(p2), 3'(p1), 3'(p0)};
  endfunction

  task automatic model_reset();
    m_since = 0;
    m_lamp = 0;
    m_idle = 1'b1;
    m_src = 0;
    m_pat = 0;
    exp_g_n = 1'b1;
    exp_r_n = 1'b1;
    exp_src = 2'd0;
    exp_idle = 1'b1;
    exp_lamp = EXP_LAMP_RST;
  endtask

  task automatic model_step();
    logic g, r, slow_on, fast_on, n_idle;
    int n_src, n_pat;
    g = 1'b0;
    r = 1'b0;
    slow_on = ((m_since / SLOW) % 2) == 0;
    fast_on = ((m_since / FAST) % 2) == 0;
    if (m_lamp < LAMP_TOTAL) begin
      if (m_lamp / LAMP == 0) r = 1'b1;
      else if (m_lamp / LAMP == 1) g = 1'b1;
    end else if (!m_idle) begin
      case (m_pat)
        1: g = 1'b1;
        2: r = 1'b1;
        3: begin g = 1'b1; r = 1'b1; end
        4: g = slow_on;
        5: r = slow_on;
        6: r = fast_on;
        7: begin g = slow_on; r = !slow_on; end
        default: ;
      endcase
    end
    exp_g_n = !g;
    exp_r_n = !r;
    exp_src = 2'(m_src);
    exp_idle = m_idle;
    if (Strobe16ms) begin
      if (m_lamp < LAMP_TOTAL) begin
        m_lamp++;
        m_since++;
      end else begin
        n_idle = 1'b1;
        n_src = 0;
        n_pat = 0;
        for (int i = 3; i >= 0; i--) begin
          if (ReqValid[i] && n_idle) begin
            n_idle = 1'b0;
            n_src = i;
            n_pat = int'(ReqPattern[3*i +: 3]);
          end
        end
        if (n_idle != m_idle || n_src != m_src || n_pat != m_pat) begin
          m_since = 0;
          m_idle = n_idle;
          m_src = n_src;
          m_pat = n_pat;
        end else begin
          m_since++;
        end
      end
    end
    exp_lamp = (m_lamp < LAMP_TOTAL);
  endtask

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_output();
    check("led_g_n", {1'b0, LED_G_N}, {1'b0, exp_g_n});
    check("led_r_n", {1'b0, LED_R_N}, {1'b0, exp_r_n});
    check("active_src", ActiveSrc, exp_src);
    check("idle", {1'b0, Idle}, {1'b0, exp_idle});
    check("lamp_test", {1'b0, LampTest}, {1'b0, exp_lamp});
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_g"}, {1'b0, LED_G_N}, 2'd1);
    check({tag, "_r"}, {1'b0, LED_R_N}, 2'd1);
    check({tag, "_src"}, ActiveSrc, 2'd0);
    check({tag, "_idle"}, {1'b0, Idle}, 2'd1);
    check({tag, "_lamp"}, {1'b0, LampTest}, {1'b0, EXP_LAMP_RST});
  endtask

  task automatic tick(input logic strobe);
    Strobe16ms = strobe;
    @(posedge SlowClock);
    model_step();
    @(negedge SlowClock);
    check_output();
  endtask

  task automatic apply_stimulus(input logic [3:0] valid, input logic [11:0] pattern, input int n_strobes);
    ReqValid = valid;
    ReqPattern = pattern;
    for (int s = 0; s < n_strobes; s++) begin
      for (int c = 0; c < STROBE_PERIOD - 1; c++) tick(1'b0);
      tick(1'b1);
    end
  endtask

  initial begin
    int idx;
    Reset_N = 1'b0;
    Strobe16ms = 1'b0;
    ReqValid = 4'b0000;
    ReqPattern = 12'h000;
    model_reset();
    @(negedge SlowClock);
    @(negedge SlowClock);
    check_reset_values("reset");
    Reset_N = 1'b1;

    $display("[TB] lamp test window with requests raised");
    apply_stimulus(4'b1111, pats(3, 6, 2, 1), LAMP_TOTAL);
    apply_stimulus(4'b0000, 12'h000, 2);

    $display("[TB] normal solid green");
    apply_stimulus(4'b0001, pats(0, 0, 0, 1), 1);
    tick(1'b0);
    check("t2_g", {1'b0, LED_G_N}, 2'd0);
    check("t2_r", {1'b0, LED_R_N}, 2'd1);
    check("t2_idle", {1'b0, Idle}, 2'd0);

    $display("[TB] fault fast red over normal");
    apply_stimulus(4'b0101, pats(0, 6, 0, 1), 1);
    tick(1'b0);
    check("t3_src", ActiveSrc, 2'd2);
    check("t3_r_on", {1'b0, LED_R_N}, 2'd0);
    apply_stimulus(4'b0101, pats(0, 6, 0, 1), 20);
    apply_stimulus(4'b0001, pats(0, 6, 0, 1), 1);
    tick(1'b0);
    check("t3_back_g", {1'b0, LED_G_N}, 2'd0);
    check("t3_back_src", ActiveSrc, 2'd0);

    $display("[TB] identify and fault together, glitch between strobes");
    apply_stimulus(4'b1101, pats(3, 6, 0, 1), 1);
    tick(1'b0);
    check("t4_src", ActiveSrc, 2'd3);
    ReqValid = 4'b0000;
    tick(1'b0);
    ReqValid = 4'b1101;
    tick(1'b1);
    tick(1'b0);
    check("t4_glitch_src", ActiveSrc, 2'd3);
    check("t4_glitch_idle", {1'b0, Idle}, 2'd0);

    $display("[TB] identify alternate then pattern rewrite");
    apply_stimulus(4'b1000, pats(7, 0, 0, 0), 75);
    apply_stimulus(4'b1000, pats(4, 0, 0, 0), 1);
    tick(1'b0);
    check("t5_restart_g", {1'b0, LED_G_N}, 2'd0);
    apply_stimulus(4'b1000, pats(4, 0, 0, 0), 30);
    tick(1'b0);
    check("t5_half_end_g", {1'b0, LED_G_N}, 2'd0);
    apply_stimulus(4'b1000, pats(4, 0, 0, 0), 1);
    tick(1'b0);
    check("t5_off_g", {1'b0, LED_G_N}, 2'd1);

    $display("[TB] randomized requests");
    for (int s = 0; s < 150; s++) begin
      if ($urandom_range(0, 11) == 0) begin
        ReqValid = 4'($urandom);
        ReqPattern = 12'($urandom);
      end
      for (int c = 0; c < STROBE_PERIOD - 1; c++) begin
        tick(1'b0);
        if ($urandom_range(0, 15) == 0) begin
          idx = int'($urandom_range(0, 3));
          ReqPattern[3*idx +: 3] = 3'($urandom);
        end
      end
      tick(1'b1);
    end

    $display("[TB] asynchronous reset mid-blink");
    apply_stimulus(4'b0100, pats(0, 5, 0, 0), 10);
    #2 Reset_N = 1'b0;
    #1 check_reset_values("async_rst");
    model_reset();
    @(negedge SlowClock);
    Reset_N = 1'b1;
    apply_stimulus(4'b0110, pats(0, 6, 2, 0), LAMP_TOTAL + 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
